// File: rtl/tx_pmd_scrambler_serializer_pkg.sv
// Shared 100BASE-TX PMD definitions: 4B/5B control codes and the x^11+x^9+1 stream cipher.
// Used by both the transmit scrambler and the receive descrambler.
package pmd_100base_tx_pkg;

  typedef logic [4:0] code_t;

  localparam code_t CODE_IDLE = 5'b11111;
  localparam code_t CODE_J    = 5'b11000;
  localparam code_t CODE_K    = 5'b10001;
  localparam code_t CODE_T    = 5'b01101;
  localparam code_t CODE_R    = 5'b00111;

  localparam int LFSR_W = 11;
  localparam int TAP_A  = 10;
  localparam int TAP_B  = 8;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 11'h7FF;

  function automatic logic lfsr_key(input logic [LFSR_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/tx_pmd_scrambler_serializer_if.sv
// Code-group handshake between the 4B/5B encoder (master) and the scrambler/serializer (slave).
interface tx_pmd_scrambler_serializer_if;
  import pmd_100base_tx_pkg::*;

  code_t in_code;
  logic  in_valid;
  logic  in_ready;

  modport master (output in_code, output in_valid, input in_ready);
  modport slave  (input in_code, input in_valid, output in_ready);

endinterface

// File: rtl/tx_pmd_scrambler_serializer_lfsr.sv
// Free-running 11-bit PMD keystream generator; reloads SEED if it ever reaches the all-zero lock-up state.
module pmd_lfsr_keystream
  import pmd_100base_tx_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic clock,
  input  logic reset,
  output logic key
);

  logic [LFSR_W-1:0] s;

  assign key = lfsr_key(s);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s <= SEED;
    end else if (s == '0) begin
      s <= SEED;
    end else begin
      s <= {s[LFSR_W-2:0], key};
    end
  end

endmodule

// File: rtl/tx_pmd_scrambler_serializer.sv
// 100BASE-TX transmit stage: accepts 5-bit code groups, serializes MSB-first and scrambles
// into one registered NRZ bit per clock, inserting IDLE whenever the encoder has nothing ready.
module tx_pmd_scrambler_serializer
  import pmd_100base_tx_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter code_t             IDLE_CODE = CODE_IDLE
) (
  input  logic                          clock,
  input  logic                          reset,
  tx_pmd_scrambler_serializer_if.slave  in_bus,
  input  logic                          scramble_enable,
  output logic                          NRZ,
  output logic                          underrun
);

  logic [2:0] bit_cnt;
  code_t      sr;
  logic       key;
  logic       load;

  pmd_lfsr_keystream #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .key   (key)
  );

  // Ready depends only on the bit counter so the upstream encoder sees no combinational loop.
  assign load            = (bit_cnt == 3'd4);
  assign in_bus.in_ready = load;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= 3'd4;
      sr       <= IDLE_CODE;
      NRZ      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      NRZ      <= sr[4] ^ (scramble_enable & key);
      underrun <= 1'b0;
      if (load) begin
        bit_cnt <= 3'd0;
        if (in_bus.in_valid) begin
          sr <= in_bus.in_code;
        end else begin
          sr       <= IDLE_CODE;
          underrun <= 1'b1;
        end
      end else begin
        sr      <= {sr[3:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_pmd_scrambler_serializer.sv
// Self-checking bench: serial stream model ({leading IDLE bit, groups MSB-first}) XOR a
// keystream built from the x^11+x^9+1 recurrence over a plain bit array.
module tb_tx_pmd_scrambler_serializer;
  import pmd_100base_tx_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic scramble_enable;
  logic NRZ;
  logic underrun;

  tx_pmd_scrambler_serializer_if bus ();

  tx_pmd_scrambler_serializer dut (
    .clock           (clock),
    .reset           (reset),
    .in_bus          (bus),
    .scramble_enable (scramble_enable),
    .NRZ             (NRZ),
    .underrun        (underrun)
  );

  always #4 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam int KEY_LEN = 4400;
  bit key_ref [KEY_LEN];

  // b[0..10] is the seed (b[0] oldest = s[10]); each new bit is b[n] ^ b[n+2].
  function automatic void build_keystream();
    bit b [KEY_LEN + 11];
    logic [10:0] seed_v;
    seed_v = DEFAULT_SEED;
    for (int i = 0; i < 11; i++) b[i] = seed_v[10 - i];
    for (int n = 0; n < KEY_LEN; n++) begin
      b[n + 11] = b[n] ^ b[n + 2];
      key_ref[n] = b[n + 11];
    end
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_code = '0;
    scramble_enable = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_code = 5'b10000;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    tests_run++;
    if (NRZ !== 1'b0) begin tests_failed++; $display("FAIL reset_nrz: got %b expected 0", NRZ); end
    tests_run++;
    if (underrun !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_bypass_basic();
    bit stream[$];
    logic [4:0] first5;
    first5 = 5'b10101;
    apply_reset();
    stream.push_back(1'b1);
    for (int n = 0; n < 15; n++) begin
      logic [4:0] c;
      c = (n == 0) ? 5'b10101 : CODE_IDLE;
      bus.in_valid = (n == 0);
      bus.in_code = 5'b10101;
      tests_run++;
      if (bus.in_ready !== 1'((n % 5) == 0)) begin
        tests_failed++; $display("FAIL bypass_ready n=%0d: got %b expected %b", n, bus.in_ready, (n % 5) == 0);
      end
      if (n % 5 == 0) for (int b = 4; b >= 0; b--) stream.push_back(c[b]);
      @(posedge clock); #1;
      tests_run++;
      if (NRZ !== stream[n]) begin
        tests_failed++; $display("FAIL bypass_nrz n=%0d: got %b expected %b", n, NRZ, stream[n]);
      end
      if (n >= 1 && n <= 5) begin
        tests_run++;
        if (NRZ !== first5[5 - n]) begin
          tests_failed++; $display("FAIL bypass_e%0d: got %b expected %b", n, NRZ, first5[5 - n]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] codes [3];
    logic [9:0] jk_bits;
    bit stream[$];
    codes[0] = CODE_J; codes[1] = CODE_K; codes[2] = CODE_T;
    jk_bits = 10'b1100010001;
    apply_reset();
    stream.push_back(1'b1);
    for (int n = 0; n < 15; n++) begin
      bus.in_valid = 1'b1;
      bus.in_code = codes[n / 5];
      if (n % 5 == 0) for (int b = 4; b >= 0; b--) stream.push_back(codes[n / 5][b]);
      @(posedge clock); #1;
      tests_run++;
      if (underrun !== 1'b0) begin
        tests_failed++; $display("FAIL b2b_underrun n=%0d: got %b expected 0", n, underrun);
      end
      tests_run++;
      if (NRZ !== stream[n]) begin
        tests_failed++; $display("FAIL b2b_nrz n=%0d: got %b expected %b", n, NRZ, stream[n]);
      end
      if (n >= 1 && n <= 10) begin
        tests_run++;
        if (NRZ !== jk_bits[10 - n]) begin
          tests_failed++; $display("FAIL b2b_jk e%0d: got %b expected %b", n, NRZ, jk_bits[10 - n]);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_underrun();
    apply_reset();
    for (int n = 0; n < 30; n++) begin
      @(posedge clock); #1;
      tests_run++;
      if (NRZ !== 1'b1) begin
        tests_failed++; $display("FAIL underrun_nrz n=%0d: got %b expected 1", n, NRZ);
      end
      tests_run++;
      if (underrun !== 1'((n % 5) == 0)) begin
        tests_failed++; $display("FAIL underrun_pulse n=%0d: got %b expected %b", n, underrun, (n % 5) == 0);
      end
    end
  endtask

  task automatic test_keystream();
    bit nrz_log[$];
    logic [10:0] first11;
    first11 = 11'b11111111100;
    apply_reset();
    scramble_enable = 1'b1;
    for (int n = 0; n < 2047 + 40; n++) begin
      @(posedge clock); #1;
      nrz_log.push_back(NRZ);
      tests_run++;
      if (NRZ !== (1'b1 ^ key_ref[n])) begin
        tests_failed++; $display("FAIL keystream n=%0d: got %b expected %b", n, NRZ, 1'b1 ^ key_ref[n]);
      end
      if (n < 11) begin
        tests_run++;
        if (NRZ !== first11[10 - n]) begin
          tests_failed++; $display("FAIL keystream_first n=%0d: got %b expected %b", n, NRZ, first11[10 - n]);
        end
      end
      if (n >= 2047) begin
        tests_run++;
        if (nrz_log[n] !== nrz_log[n - 2047]) begin
          tests_failed++; $display("FAIL keystream_period n=%0d: got %b expected %b", n, nrz_log[n], nrz_log[n - 2047]);
        end
      end
    end
    scramble_enable = 1'b0;
  endtask

  task automatic test_random();
    bit stream[$];
    apply_reset();
    stream.push_back(1'b1);
    for (int n = 0; n < 500; n++) begin
      bit v;
      bit se;
      logic [4:0] c;
      bit exp_nrz;
      bit exp_ur;
      v = ($urandom_range(0, 9) < 7);
      se = 1'($urandom_range(0, 1));
      c = 5'($urandom);
      bus.in_valid = v;
      bus.in_code = c;
      scramble_enable = se;
      tests_run++;
      if (bus.in_ready !== 1'((n % 5) == 0)) begin
        tests_failed++; $display("FAIL random_ready n=%0d: got %b expected %b", n, bus.in_ready, (n % 5) == 0);
      end
      if (n % 5 == 0) begin
        if (!v) c = CODE_IDLE;
        for (int b = 4; b >= 0; b--) stream.push_back(c[b]);
      end
      exp_nrz = stream[n] ^ (se & key_ref[n]);
      exp_ur = ((n % 5) == 0) && !v;
      @(posedge clock); #1;
      tests_run++;
      if (NRZ !== exp_nrz) begin
        tests_failed++; $display("FAIL random_nrz n=%0d: got %b expected %b", n, NRZ, exp_nrz);
      end
      tests_run++;
      if (underrun !== exp_ur) begin
        tests_failed++; $display("FAIL random_underrun n=%0d: got %b expected %b", n, underrun, exp_ur);
      end
    end
    bus.in_valid = 1'b0;
    scramble_enable = 1'b0;
  endtask

  task automatic test_reset_mid_group();
    bit stream[$];
    logic [4:0] c2;
    c2 = 5'b01001;
    apply_reset();
    scramble_enable = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_code = 5'b10110;
    repeat (4) begin @(posedge clock); #1; bus.in_valid = 1'b0; end
    reset = 1'b1;
    #1;
    tests_run++;
    if (NRZ !== 1'b0) begin tests_failed++; $display("FAIL midreset_nrz: got %b expected 0", NRZ); end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_ready: got %b expected 1", bus.in_ready); end
    tests_run++;
    if (dut.u_lfsr.s !== DEFAULT_SEED) begin
      tests_failed++; $display("FAIL midreset_lfsr: got %h expected %h", dut.u_lfsr.s, DEFAULT_SEED);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    stream.push_back(1'b1);
    for (int b = 4; b >= 0; b--) stream.push_back(c2[b]);
    bus.in_valid = 1'b1;
    bus.in_code = c2;
    for (int n = 0; n < 6; n++) begin
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      tests_run++;
      if (NRZ !== (stream[n] ^ key_ref[n])) begin
        tests_failed++; $display("FAIL midreset_stream n=%0d: got %b expected %b", n, NRZ, stream[n] ^ key_ref[n]);
      end
    end
    scramble_enable = 1'b0;
  endtask

  task automatic test_lockup();
    apply_reset();
    scramble_enable = 1'b1;
    for (int n = 0; n < 13; n++) begin
      @(posedge clock); #1;
      tests_run++;
      if (NRZ !== (1'b1 ^ key_ref[n])) begin
        tests_failed++; $display("FAIL lockup_pre n=%0d: got %b expected %b", n, NRZ, 1'b1 ^ key_ref[n]);
      end
    end
    force dut.u_lfsr.s = '0;
    @(negedge clock);
    release dut.u_lfsr.s;
    @(posedge clock); #1;
    tests_run++;
    if (NRZ !== 1'b1) begin tests_failed++; $display("FAIL lockup_zero_key: got %b expected 1", NRZ); end
    tests_run++;
    if (dut.u_lfsr.s !== DEFAULT_SEED) begin
      tests_failed++; $display("FAIL lockup_reload: got %h expected %h", dut.u_lfsr.s, DEFAULT_SEED);
    end
    for (int j = 0; j < 20; j++) begin
      @(posedge clock); #1;
      tests_run++;
      if (NRZ !== (1'b1 ^ key_ref[j])) begin
        tests_failed++; $display("FAIL lockup_resume j=%0d: got %b expected %b", j, NRZ, 1'b1 ^ key_ref[j]);
      end
    end
    scramble_enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    build_keystream();
    test_reset();
    test_bypass_basic();
    test_back_to_back();
    test_underrun();
    test_keystream();
    test_random();
    test_reset_mid_group();
    test_lockup();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
